system_server_cpu_div_cell: RTL

SYSTEM_SERVER_CPU_DIV_CELL -- requirements
Module: system_server_cpu_div_cell

---
 rtl/system_server_cpu_div_cell.sv | 131 +++++++++++++
 1 files changed

// File: rtl/system_server_cpu_div_cell.sv
// system_server_cpu_div_cell: 32-bit signed/unsigned radix-2 restoring divider
// with a fixed 35-cycle start-to-done latency and abort support.
`default_nettype none

module system_server_cpu_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  input  logic        E_div_start,
  input  logic        E_div_signed,
  input  logic        E_div_abort,
  output logic [31:0] M_div_quot,
  output logic [31:0] M_div_rem,
  output logic        M_div_busy,
  output logic        M_div_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] src1_q, src2_q;
  logic        signed_q;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem_acc;
  logic [4:0]  cnt;
  logic        q_neg, r_neg;

  logic [31:0] abs1, abs2;
  logic [32:0] shifted, diff;
  logic [31:0] quot_fix, rem_fix;
  logic        div_zero, ovf;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (E_div_start && !E_div_abort) state_nxt = PREP;
      PREP:    state_nxt = E_div_abort ? IDLE : ITER;
      ITER:    if (E_div_abort)      state_nxt = IDLE;
               else if (cnt == 5'd0) state_nxt = FIXUP;
      FIXUP:   state_nxt = E_div_abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    abs1     = (signed_q && src1_q[31]) ? (~src1_q + 32'd1) : src1_q;
    abs2     = (signed_q && src2_q[31]) ? (~src2_q + 32'd1) : src2_q;
    shifted  = {rem_acc, dvd[31]};
    diff     = shifted - {1'b0, dvs};
    div_zero = (src2_q == 32'd0);
    ovf      = signed_q && (src1_q == 32'h8000_0000) && (src2_q == 32'hFFFF_FFFF);
    quot_fix = q_neg ? (~dvd + 32'd1) : dvd;
    rem_fix  = r_neg ? (~rem_acc + 32'd1) : rem_acc;
    // Special cases override whatever the iteration produced.
    if (div_zero) begin
      quot_fix = 32'hFFFF_FFFF;
      rem_fix  = src1_q;
    end else if (ovf) begin
      quot_fix = 32'h8000_0000;
      rem_fix  = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      src1_q     <= 32'd0;
      src2_q     <= 32'd0;
      signed_q   <= 1'b0;
      dvd        <= 32'd0;
      dvs        <= 32'd0;
      rem_acc    <= 32'd0;
      cnt        <= 5'd0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      M_div_quot <= 32'd0;
      M_div_rem  <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (E_div_start && !E_div_abort) begin
            src1_q   <= E_src1;
            src2_q   <= E_src2;
            signed_q <= E_div_signed;
          end
        end
        PREP: begin
          if (!E_div_abort) begin
            dvd     <= abs1;
            dvs     <= abs2;
            rem_acc <= 32'd0;
            cnt     <= 5'd31;
            q_neg   <= signed_q && (src1_q[31] ^ src2_q[31]);
            r_neg   <= signed_q && src1_q[31];
          end
        end
        ITER: begin
          if (!E_div_abort) begin
            // Restoring step: keep the trial difference only when it is non-negative.
            rem_acc <= diff[32] ? shifted[31:0] : diff[31:0];
            dvd     <= {dvd[30:0], ~diff[32]};
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
          end
        end
        FIXUP: begin
          if (!E_div_abort) begin
            M_div_quot <= quot_fix;
            M_div_rem  <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign M_div_busy = (state != IDLE);
  assign M_div_done = (state == DONE);

endmodule

`default_nettype wire
